mmv_ram_responder: RTL and testbench
====================================

# mmv_ram_responder

Memory-mapped slave that answers the MemoryMapped master interface (addr/wreq/wdat/rreq/rdat/rval/busy) from an internal 2^AWIDTH x DWIDTH RAM. Fixed read latency, self-initialisation sweep, optional periodic backpressure and a programmable stuck-bit fault. Sits opposite RAM testers and other MemoryMapped initiators as a synthesizable target for benches and on-chip self-test loops.

## Interface
- AWIDTH, 4: address width; RAM depth 2^AWIDTH words
- DWIDTH, 16: data width
- RDDELAY, 2: read latency in cycles, RDDELAY >= 1
- INITVAL, 0: word written to every cell by the init sweep
- BUSYGAP, 0: if > 0, s_busy is forced high one cycle out of every BUSYGAP idle cycles; 0 disables
- FAULTADDR, 0: address of the faulty cell
- FAULTMASK, 0: bits set here are stored as 0 on every write to FAULTADDR; 0 disables

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous request to flush reads and restart the init sweep
- s_addr  in  AWIDTH  transaction address
- s_wreq  in  1  write request
- s_wdat  in  DWIDTH  write data
- s_rreq  in  1  read request
- s_rdat  out  DWIDTH  read data, valid with s_rval
- s_rval  out  1  read data valid, one-cycle pulse per accepted read
- s_busy  out  1  slave cannot accept a request this cycle

## Operation
- States: INIT, RUN.
- Reset (reset low): state INIT, init counter 0, BUSYGAP counter 0, read pipeline cleared; s_rdat 0, s_rval 0, s_busy 1.
- INIT: each cycle writes INITVAL to RAM[init counter], then increments the counter; s_busy 1 throughout. After writing address 2^AWIDTH-1, go to RUN. INITVAL is written unmasked (FAULTMASK does not apply).
- RUN: a request is accepted in any cycle with (s_wreq | s_rreq) & ~s_busy.
- Accepted write: RAM[s_addr] <= s_wdat & ~FAULTMASK if s_addr == FAULTADDR, else s_wdat.
- Accepted read: RAM[s_addr] is sampled read-first, i.e. before any write accepted in the same cycle, and enters a RDDELAY-deep valid/data pipeline.
- s_wreq and s_rreq together: both accepted at the same address; the read returns the old contents.
- A requester must hold its request while s_busy is high. The slave ignores requests while busy and never latches them.
- BUSYGAP > 0: a free-running counter in RUN raises s_busy for one cycle each time it reaches BUSYGAP-1, then wraps to 0. The counter holds 0 in INIT.
- clear high in any state: on the next edge flush every in-flight read, with no s_rval for it; reset the init counter to 0 and enter INIT. If clear is held, INIT restarts every cycle.
- s_rdat keeps its last value while s_rval is low; it is not zeroed.
- Reads in flight keep draining during a BUSYGAP busy cycle. Busy only blocks new acceptance.

## Timing
- After reset deasserts: s_busy is 1 for exactly 2^AWIDTH cycles, then 0 in the first RUN cycle. This is 16 cycles with the defaults.
- Read latency: a read accepted on edge k gives s_rval=1 and s_rdat valid in the cycle after edge k+RDDELAY-1. With RDDELAY=1 this is the cycle right after acceptance.
- Back-to-back reads, one per cycle, give back-to-back s_rval pulses in the same order. Throughput is 1 request per cycle.
- A write accepted on edge k is visible to a read accepted on edge k+1 or later.
- s_busy is registered, with no combinational path from any s_* input. s_rval and s_rdat are registered outputs.
- Asynchronous reset mid-read discards the read: s_rval drops immediately and does not reassert for it.

## Test plan
- Reset release, defaults: s_busy high for 16 cycles, then low. Reading each of addr 0..15 returns 0x0000 with s_rval exactly 2 cycles after acceptance.
- Write 0xA5A5 to addr 7, read addr 7 on the next cycle -> s_rdat 0xA5A5, single s_rval pulse.
- Same cycle: s_wreq and s_rreq to addr 2 holding 0x1111, with s_wdat 0x2222 -> read returns 0x1111; a following read returns 0x2222.
- FAULTADDR=3, FAULTMASK=0x0001: write 0xFFFF to addr 3 then read -> 0xFFFE. Addr 4 under the same write/read -> 0xFFFF.
- BUSYGAP=4 with continuous reads -> s_busy pulses every 4th cycle. Each held request is accepted on the next non-busy cycle. The count of s_rval pulses equals the count of accepted reads, and data order is preserved.
- Three reads in flight with RDDELAY=4, then clear -> no s_rval for any of them, s_busy high for 16 cycles, and all cells read back INITVAL afterwards.

Source files
------------

// File: rtl/mmv_ram_responder.sv
// MemoryMapped slave backed by an internal RAM: init sweep, fixed read latency,
// optional periodic busy insertion and a stuck-at-zero fault on one cell.
module mmv_ram_responder #(
  parameter int AWIDTH    = 4,
  parameter int DWIDTH    = 16,
  parameter int RDDELAY   = 2,
  parameter int INITVAL   = 0,
  parameter int BUSYGAP   = 0,
  parameter int FAULTADDR = 0,
  parameter int FAULTMASK = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [AWIDTH-1:0] s_addr,
  input  logic              s_wreq,
  input  logic [DWIDTH-1:0] s_wdat,
  input  logic              s_rreq,
  output logic [DWIDTH-1:0] s_rdat,
  output logic              s_rval,
  output logic              s_busy,
  output logic              o_state
);

  // Handshake: a request is taken on any edge where (s_wreq | s_rreq) is high and
  // s_busy was low in that cycle; while s_busy is high requests are ignored, not queued.

  localparam int DEPTH = 1 << AWIDTH;
  localparam int GW    = (BUSYGAP > 1) ? $clog2(BUSYGAP) : 1;
  localparam logic [GW-1:0]     GAP_LAST  = (BUSYGAP > 0) ? GW'(BUSYGAP - 1) : '0;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH-1:0] F_ADDR    = AWIDTH'(FAULTADDR);
  localparam logic [DWIDTH-1:0] F_MASK    = DWIDTH'(FAULTMASK);
  localparam logic [DWIDTH-1:0] INIT_WORD = DWIDTH'(INITVAL);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        r_state;
  logic [AWIDTH-1:0] r_init_cnt;
  logic [GW-1:0]     r_gap_cnt;
  logic              r_busy;
  logic [RDDELAY-1:0] r_pv;
  logic [DWIDTH-1:0] r_pd [RDDELAY];
  logic [DWIDTH-1:0] r_mem [DEPTH];

  logic [0:0]        w_state_nx;
  logic [AWIDTH-1:0] w_init_nx;
  logic [GW-1:0]     w_gap_nx;
  logic              w_busy_nx;
  logic              w_accept;
  logic              w_acc_rd;
  logic              w_acc_wr;
  logic [DWIDTH-1:0] w_wdat_eff;
  logic [DWIDTH-1:0] w_rd_word;

  assign w_accept   = (r_state == ST_RUN) & ~r_busy & ~clear;
  assign w_acc_rd   = w_accept & s_rreq;
  assign w_acc_wr   = w_accept & s_wreq;
  assign w_wdat_eff = (s_addr == F_ADDR) ? (s_wdat & ~F_MASK) : s_wdat;
  assign w_rd_word  = r_mem[s_addr];

  always_comb begin
    w_state_nx = r_state;
    w_init_nx  = r_init_cnt;
    w_gap_nx   = '0;
    if (clear) begin
      w_state_nx = ST_INIT;
      w_init_nx  = '0;
    end else if (r_state == ST_INIT) begin
      w_init_nx = r_init_cnt + 1'b1;
      if (r_init_cnt == LAST_ADDR) w_state_nx = ST_RUN;
    end else if (BUSYGAP > 0) begin
      w_gap_nx = (r_gap_cnt == GAP_LAST) ? '0 : r_gap_cnt + 1'b1;
    end
    // Busy is computed one cycle ahead so the output is a plain register.
    w_busy_nx = (w_state_nx == ST_INIT) | ((BUSYGAP > 0) && (w_gap_nx == GAP_LAST));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_gap_cnt  <= '0;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_init_cnt <= w_init_nx;
      r_gap_cnt  <= w_gap_nx;
      r_busy     <= w_busy_nx;
    end
  end

  // RAM has no reset; the init sweep gives it defined contents.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (r_state == ST_INIT) r_mem[r_init_cnt] <= INIT_WORD;
      else if (w_acc_wr)      r_mem[s_addr]     <= w_wdat_eff;
    end
  end

  // Data stages only move with their valid bit, so s_rdat holds between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pv <= '0;
      for (int i = 0; i < RDDELAY; i++) r_pd[i] <= '0;
    end else begin
      if (clear) begin
        r_pv <= '0;
      end else begin
        r_pv[0] <= w_acc_rd;
        for (int i = 1; i < RDDELAY; i++) r_pv[i] <= r_pv[i-1];
      end
      if (w_acc_rd) r_pd[0] <= w_rd_word;
      for (int i = 1; i < RDDELAY; i++) begin
        if (r_pv[i-1] && !clear) r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign s_rdat  = r_pd[RDDELAY-1];
  assign s_rval  = r_pv[RDDELAY-1];
  assign s_busy  = r_busy;
  assign o_state = r_state;

endmodule

// File: tb/tb_mmv_ram_responder.sv
// Scoreboard bench: instance a uses defaults plus a fault on addr 3, instance b
// uses RDDELAY=4, BUSYGAP=4, INITVAL=0x5A5A for backpressure and clear.
module tb_mmv_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;

  logic        a_clear, a_wreq, a_rreq, a_rval, a_busy, a_state;
  logic [3:0]  a_addr;
  logic [15:0] a_wdat, a_rdat;
  logic        b_clear, b_wreq, b_rreq, b_rval, b_busy, b_state;
  logic [3:0]  b_addr;
  logic [15:0] b_wdat, b_rdat;

  logic [15:0] exp_q_a[$];
  int          exp_t_a[$];
  logic [15:0] exp_q_b[$];
  int          exp_t_b[$];

  logic [15:0] mon_a_e, mon_b_e;
  int          mon_a_t, mon_b_t;
  int          n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmv_ram_responder #(.FAULTADDR(3), .FAULTMASK(1)) u_a (
    .clk(clk), .reset(rst_n), .clear(a_clear), .s_addr(a_addr), .s_wreq(a_wreq),
    .s_wdat(a_wdat), .s_rreq(a_rreq), .s_rdat(a_rdat), .s_rval(a_rval),
    .s_busy(a_busy), .o_state(a_state)
  );

  mmv_ram_responder #(.RDDELAY(4), .BUSYGAP(4), .INITVAL(16'h5A5A)) u_b (
    .clk(clk), .reset(rst_n), .clear(b_clear), .s_addr(b_addr), .s_wreq(b_wreq),
    .s_wdat(b_wdat), .s_rreq(b_rreq), .s_rdat(b_rdat), .s_rval(b_rval),
    .s_busy(b_busy), .o_state(b_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? a_busy : b_busy;
  endfunction

  // Drive one request, hold it through busy cycles, log expected read data.
  task automatic do_req(input int sel, input bit wr, input bit rd, input logic [3:0] addr,
                        input logic [15:0] wdat, input logic [15:0] exp);
    int w = 0;
    @(negedge clk);
    if (sel == 0) begin
      a_wreq = wr; a_rreq = rd; a_addr = addr; a_wdat = wdat;
    end else begin
      b_wreq = wr; b_rreq = rd; b_addr = addr; b_wdat = wdat;
    end
    while (busy_of(sel) && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (w >= 64) begin
      checks++;
      fails++;
      $display("FAIL req_timeout: inst %0d addr %0d still busy after %0d cycles", sel, addr, w);
    end else if (rd) begin
      if (sel == 0) begin
        exp_q_a.push_back(exp); exp_t_a.push_back(cyc + 2);
      end else begin
        exp_q_b.push_back(exp); exp_t_b.push_back(cyc + 4);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    a_wreq = 0; a_rreq = 0; a_clear = 0;
    b_wreq = 0; b_rreq = 0; b_clear = 0;
  endtask

  task automatic drain(input int sel);
    int w = 0;
    while (((sel == 0) ? exp_q_a.size() : exp_q_b.size()) != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check((sel == 0) ? "a_drain_pending" : "b_drain_pending",
          (sel == 0) ? exp_q_a.size() : exp_q_b.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && a_rval) begin
      if (exp_q_a.size() == 0) begin
        checks++; fails++;
        $display("FAIL a_unexpected_rval: got data %h expected no pulse", a_rdat);
      end else begin
        mon_a_e = exp_q_a.pop_front();
        mon_a_t = exp_t_a.pop_front();
        check("a_rdat", a_rdat, mon_a_e);
        check("a_latency_cycle", cyc, mon_a_t);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_rval) begin
      if (exp_q_b.size() == 0) begin
        checks++; fails++;
        $display("FAIL b_unexpected_rval: got data %h expected no pulse", b_rdat);
      end else begin
        mon_b_e = exp_q_b.pop_front();
        mon_b_t = exp_t_b.pop_front();
        check("b_rdat", b_rdat, mon_b_e);
        check("b_latency_cycle", cyc, mon_b_t);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    a_clear = 0; a_wreq = 0; a_rreq = 0; a_addr = '0; a_wdat = '0;
    b_clear = 0; b_wreq = 0; b_rreq = 0; b_addr = '0; b_wdat = '0;
    repeat (3) @(negedge clk);
    check("a_reset_busy", a_busy, 1);
    check("a_reset_rval", a_rval, 0);
    check("a_reset_rdat", a_rdat, 16'h0000);
    check("b_reset_busy", b_busy, 1);
    check("b_reset_rval", b_rval, 0);
    rst_n = 1;

    check("b_busy_at_release", b_busy, 1);
    n = 0;
    while (a_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("a_init_busy_cycles", n, 16);
    check("b_busy_first_run", b_busy, 0);
    for (int j = 1; j < 12; j++) begin
      @(negedge clk);
      check("b_gap_pattern", 32'(b_busy), (j % 4 == 3) ? 1 : 0);
    end

    // Instance a: init contents, write/read, read-first collision, fault cell.
    for (int i = 0; i < 16; i++) do_req(0, 0, 1, 4'(i), 16'h0, 16'h0000);
    do_req(0, 1, 0, 4'd7, 16'hA5A5, 16'h0);
    do_req(0, 0, 1, 4'd7, 16'h0, 16'hA5A5);
    do_req(0, 1, 0, 4'd2, 16'h1111, 16'h0);
    do_req(0, 1, 1, 4'd2, 16'h2222, 16'h1111);
    do_req(0, 0, 1, 4'd2, 16'h0, 16'h2222);
    do_req(0, 1, 0, 4'd3, 16'hFFFF, 16'h0);
    do_req(0, 0, 1, 4'd3, 16'h0, 16'hFFFE);
    do_req(0, 1, 0, 4'd4, 16'hFFFF, 16'h0);
    do_req(0, 0, 1, 4'd4, 16'h0, 16'hFFFF);
    idle();
    drain(0);

    // Instance b: writes and continuous reads under periodic busy.
    for (int i = 0; i < 8; i++) do_req(1, 1, 0, 4'(i), 16'h1000 + 16'(i) * 16'h0101, 16'h0);
    for (int i = 0; i < 8; i++) do_req(1, 0, 1, 4'(i), 16'h0, 16'h1000 + 16'(i) * 16'h0101);
    do_req(1, 0, 1, 4'd8, 16'h0, 16'h5A5A);
    do_req(1, 0, 1, 4'd9, 16'h0, 16'h5A5A);
    idle();
    drain(1);

    // Align to a busy cycle so the three reads land on consecutive edges.
    n = 0;
    while (!b_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("b_busy_seen_before_clear", b_busy, 1);
    do_req(1, 0, 1, 4'd0, 16'h0, 16'h1000);
    do_req(1, 0, 1, 4'd1, 16'h0, 16'h1101);
    do_req(1, 0, 1, 4'd2, 16'h0, 16'h1202);
    @(negedge clk);
    b_rreq = 0;
    b_clear = 1;
    exp_q_b.delete();
    exp_t_b.delete();
    @(negedge clk);
    b_clear = 0;
    n = 0;
    while (b_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("b_clear_busy_cycles", n, 16);
    check("b_rval_after_clear", b_rval, 0);
    for (int i = 0; i < 16; i++) do_req(1, 0, 1, 4'(i), 16'h0, 16'h5A5A);
    idle();
    drain(1);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
